rob_param: RTL and testbench
============================

ROB_PARAM -- requirements
Module: rob_param

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count, power of two, 4..64.
REQ-002 SHALL have parameter WB_PORTS, default 4, number of completion ports, 1..8.
REQ-003 SHALL have parameter DATA_W, default 32, width of result value and PC.
REQ-004 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- alloc_valid  in  1  dispatch requests one entry.
- alloc_ready  out  1  entry can be accepted.
- alloc_tag  out  log2(DEPTH)  index the entry receives.
- alloc_dest  in  5  destination register.
- alloc_reg_write, alloc_mem_write  in  1 each  commit side effects.
- alloc_pc  in  DATA_W  instruction PC.
- wb_valid  in  WB_PORTS  per-port completion strobe.
- wb_tag  in  WB_PORTS*log2(DEPTH)  packed completing tags.
- wb_value  in  WB_PORTS*DATA_W  packed results.
- wb_exc  in  WB_PORTS  completion carries an exception.
- wb_cause  in  WB_PORTS*2  packed exception causes.
- flush_valid  in  1  branch mispredict.
- flush_tag  in  log2(DEPTH)  mispredicted branch tag.
- commit_valid  out  1  one entry retired this cycle.
- commit_dest  out  5; commit_value  out  DATA_W; commit_reg_write, commit_mem_write  out  1 each.
- exc_valid  out  1  precise exception pulse.
- exc_epc  out  DATA_W; exc_cause  out  2.
- count  out  log2(DEPTH)+1  occupied entries.

Function
REQ-005 Each entry SHALL hold valid, done, exc, cause[1:0], dest, reg_write, mem_write, pc, value.
REQ-006 alloc_ready SHALL be combinational: (count != DEPTH) && !flush_valid && rst; alloc_tag SHALL equal tail.
REQ-007 Allocation SHALL fire when alloc_valid && alloc_ready: entry[tail] written with valid=1, done=0, exc=0; tail increments modulo DEPTH.
REQ-008 Allocation SHALL use registered count only; a same-cycle commit SHALL NOT make a full buffer accept.
REQ-009 A wb port SHALL set done=1, value, exc and cause on entry[wb_tag] only if that entry is valid and not done; otherwise the write SHALL be ignored.
REQ-010 If two or more ports target the same tag in one cycle, the lowest port index SHALL win.
REQ-011 A wb to a tag allocated in the same cycle SHALL be ignored.
REQ-012 Commit: when entry[head] is valid, done and exc=0, commit_* SHALL be registered from it at the same edge, the entry invalidated, and head incremented modulo DEPTH; otherwise commit_valid SHALL be 0 next cycle.
REQ-013 Latency SHALL be one cycle: wb sampled at edge E for the head entry yields commit_valid high in the cycle after edge E+1.
REQ-014 When entry[head] is valid, done and exc=1: exc_valid SHALL pulse for one cycle, exc_epc=pc and exc_cause=cause; all entries SHALL be invalidated, head=tail=0, count=0; commit_valid SHALL be 0.
REQ-015 Flush: with flush_valid and entry[flush_tag] valid, all entries younger than flush_tag SHALL be invalidated and tail set to flush_tag+1 modulo DEPTH; entry[flush_tag] SHALL be kept.
REQ-016 Flush with flush_tag naming an invalid entry SHALL be ignored.
REQ-017 Flush and head exception in the same cycle: exception SHALL win.
REQ-018 Flush and head commit in the same cycle SHALL both take effect; count SHALL equal ((flush_tag - head) mod DEPTH) + 1 - commit.
REQ-019 Otherwise count SHALL update as count + alloc_fire - commit_fire.
REQ-020 exc_epc and exc_cause SHALL hold their last value until the next exception.

Reset
REQ-021 With rst=0 at a clock edge: head, tail and count SHALL be 0, every entry invalid, and all outputs 0 except alloc_ready, which SHALL be 0 while rst=0.
REQ-022 Reset asserted mid-operation SHALL discard all in-flight entries; no commit or exc pulse SHALL follow.

Configuration
REQ-023 With ROB_PERF_EN defined: ports perf_commits (out, 32) and perf_full_cycles (out, 32) SHALL count commit_fire and cycles with count==DEPTH && alloc_valid, wrap at 2^32 and reset to 0; without it these ports and counters SHALL NOT exist.

Verification
REQ-024 Reset, then allocate 16 entries with DEPTH=16 -> count=16 and alloc_ready=0; 17th alloc_valid is not accepted.
REQ-025 Allocate tags 0..3, complete them in order 3,2,1,0 -> commits occur in order 0,1,2,3, one per cycle, after tag 0 completes.
REQ-026 Ports 0 and 2 complete tag 5 with 0xAAAA and 0x5555 in one cycle -> commit_value=0xAAAA.
REQ-027 Allocate tags 0..7, flush_tag=3 -> count=4, alloc_tag=4; later wb to tag 6 is ignored.
REQ-028 Head tag 0 completes with wb_exc=1, cause=2'b10, pc=0x100 -> one-cycle exc_valid, exc_epc=0x100, exc_cause=2'b10, count=0.
REQ-029 Wrap-around: run 40 alloc/commit pairs with DEPTH=16 -> tags wrap 15->0, commit order is preserved, and perf_commits=40 with ROB_PERF_EN defined.

Source files
------------

// File: rtl/rob_param.sv
// Reorder buffer: in-order allocate, out-of-order writeback, in-order commit,
// precise exceptions and branch flush. Define ROB_PERF_EN to add perf counters.
module rob_param #(
  parameter int DEPTH    = 16,
  parameter int WB_PORTS = 4,
  parameter int DATA_W   = 32,
  localparam int TW      = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  output logic [TW-1:0]              alloc_tag,
  input  logic [4:0]                 alloc_dest,
  input  logic                       alloc_reg_write,
  input  logic                       alloc_mem_write,
  input  logic [DATA_W-1:0]          alloc_pc,
  input  logic [WB_PORTS-1:0]        wb_valid,
  input  logic [WB_PORTS*TW-1:0]     wb_tag,
  input  logic [WB_PORTS*DATA_W-1:0] wb_value,
  input  logic [WB_PORTS-1:0]        wb_exc,
  input  logic [WB_PORTS*2-1:0]      wb_cause,
  input  logic                       flush_valid,
  input  logic [TW-1:0]              flush_tag,
  output logic                       commit_valid,
  output logic [4:0]                 commit_dest,
  output logic [DATA_W-1:0]          commit_value,
  output logic                       commit_reg_write,
  output logic                       commit_mem_write,
  output logic                       exc_valid,
  output logic [DATA_W-1:0]          exc_epc,
  output logic [1:0]                 exc_cause,
  output logic [TW:0]                count
`ifdef ROB_PERF_EN
  ,
  output logic [31:0]                perf_commits,
  output logic [31:0]                perf_full_cycles
`endif
);

  localparam logic [TW:0] FULL = (TW+1)'(DEPTH);

  logic [DEPTH-1:0]  r_valid, r_done, r_exc;
  logic [1:0]        r_cause [DEPTH];
  logic [4:0]        r_dest  [DEPTH];
  logic [DEPTH-1:0]  r_rw, r_mw;
  logic [DATA_W-1:0] r_pc    [DEPTH];
  logic [DATA_W-1:0] r_value [DEPTH];

  logic [TW-1:0]     r_head, r_tail;
  logic [TW:0]       r_count;
  logic              r_commit_valid, r_commit_rw, r_commit_mw, r_exc_valid;
  logic [4:0]        r_commit_dest;
  logic [DATA_W-1:0] r_commit_value, r_exc_epc;
  logic [1:0]        r_exc_cause;

  logic              w_alloc_fire, w_head_live, w_commit, w_exc_fire, w_flush;
  logic [TW-1:0]     w_flush_off;
  logic [TW:0]       w_count_nxt;
  logic [TW-1:0]     w_wb_tag [WB_PORTS];
  logic [WB_PORTS-1:0] w_wb_ok;

  assign alloc_ready  = (r_count != FULL) && !flush_valid && rst;
  assign w_alloc_fire = alloc_valid && alloc_ready;
  assign w_head_live  = r_valid[r_head] && r_done[r_head];
  assign w_commit     = w_head_live && !r_exc[r_head];
  assign w_exc_fire   = w_head_live && r_exc[r_head];
  assign w_flush      = flush_valid && r_valid[flush_tag] && !w_exc_fire;
  // Age of the flushing branch relative to head; entries further away are younger.
  assign w_flush_off  = flush_tag - r_head;

  // Writeback qualification: target must be live, not yet done, not allocated now.
  always_comb begin
    w_wb_ok = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      w_wb_tag[p] = wb_tag[p*TW +: TW];
      w_wb_ok[p]  = wb_valid[p] && r_valid[w_wb_tag[p]] && !r_done[w_wb_tag[p]]
                    && !(w_alloc_fire && (r_tail == w_wb_tag[p]));
    end
  end

  // Next occupancy: exception clears, flush truncates, else alloc/commit delta.
  always_comb begin
    w_count_nxt = r_count;
    if (w_exc_fire) begin
      w_count_nxt = '0;
    end else if (w_flush) begin
      w_count_nxt = {1'b0, w_flush_off} + (TW+1)'(1) - (TW+1)'(w_commit);
    end else begin
      w_count_nxt = r_count + (TW+1)'(w_alloc_fire) - (TW+1)'(w_commit);
    end
  end

  // Entry storage: allocate, retire/flush invalidation, writeback.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= '0;
      r_done  <= '0;
      r_exc   <= '0;
    end else if (w_exc_fire) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_alloc_fire && (r_tail == TW'(i))) begin
          r_valid[i] <= 1'b1;
          r_done[i]  <= 1'b0;
          r_exc[i]   <= 1'b0;
          r_dest[i]  <= alloc_dest;
          r_rw[i]    <= alloc_reg_write;
          r_mw[i]    <= alloc_mem_write;
          r_pc[i]    <= alloc_pc;
        end else if ((w_commit && (r_head == TW'(i)))
                     || (w_flush && ((TW'(i) - r_head) > w_flush_off))) begin
          r_valid[i] <= 1'b0;
        end
      end
      // Descending order so the lowest-numbered port's write lands last and wins.
      for (int p = WB_PORTS - 1; p >= 0; p--) begin
        if (w_wb_ok[p]) begin
          r_done[w_wb_tag[p]]  <= 1'b1;
          r_exc[w_wb_tag[p]]   <= wb_exc[p];
          r_cause[w_wb_tag[p]] <= wb_cause[p*2 +: 2];
          r_value[w_wb_tag[p]] <= wb_value[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Pointers, occupancy and registered commit/exception outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_commit_valid <= 1'b0;
      r_commit_dest  <= 5'd0;
      r_commit_value <= '0;
      r_commit_rw    <= 1'b0;
      r_commit_mw    <= 1'b0;
      r_exc_valid    <= 1'b0;
      r_exc_epc      <= '0;
      r_exc_cause    <= 2'b00;
    end else begin
      r_count        <= w_count_nxt;
      r_commit_valid <= w_commit;
      r_exc_valid    <= w_exc_fire;
      if (w_commit) begin
        r_commit_dest  <= r_dest[r_head];
        r_commit_value <= r_value[r_head];
        r_commit_rw    <= r_rw[r_head];
        r_commit_mw    <= r_mw[r_head];
      end
      if (w_exc_fire) begin
        r_head      <= '0;
        r_tail      <= '0;
        r_exc_epc   <= r_pc[r_head];
        r_exc_cause <= r_cause[r_head];
      end else begin
        if (w_commit) r_head <= r_head + TW'(1);
        if (w_flush) r_tail <= flush_tag + TW'(1);
        else if (w_alloc_fire) r_tail <= r_tail + TW'(1);
      end
    end
  end

  assign alloc_tag        = r_tail;
  assign count            = r_count;
  assign commit_valid     = r_commit_valid;
  assign commit_dest      = r_commit_dest;
  assign commit_value     = r_commit_value;
  assign commit_reg_write = r_commit_rw;
  assign commit_mem_write = r_commit_mw;
  assign exc_valid        = r_exc_valid;
  assign exc_epc          = r_exc_epc;
  assign exc_cause        = r_exc_cause;

`ifdef ROB_PERF_EN
  logic [31:0] r_perf_commits, r_perf_full;

  // Free-running retire and full-stall counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_commits <= 32'd0;
      r_perf_full    <= 32'd0;
    end else begin
      r_perf_commits <= r_perf_commits + 32'(w_commit);
      if ((r_count == FULL) && alloc_valid) r_perf_full <= r_perf_full + 32'd1;
    end
  end

  assign perf_commits     = r_perf_commits;
  assign perf_full_cycles = r_perf_full;
`endif

endmodule

// File: tb/tb_rob_param.sv
// Directed self-checking bench for rob_param (DEPTH=16, 4 writeback ports).
module tb_rob_param;
  localparam int DEPTH = 16, WBP = 4, DW = 32, TW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b0;
  logic             alloc_valid = 1'b0, alloc_ready;
  logic [TW-1:0]    alloc_tag;
  logic [4:0]       alloc_dest = 5'd0;
  logic             alloc_reg_write = 1'b0, alloc_mem_write = 1'b0;
  logic [DW-1:0]    alloc_pc = 32'd0;
  logic [WBP-1:0]   wb_valid = '0, wb_exc = '0;
  logic [WBP*TW-1:0] wb_tag = '0;
  logic [WBP*DW-1:0] wb_value = '0;
  logic [WBP*2-1:0] wb_cause = '0;
  logic             flush_valid = 1'b0;
  logic [TW-1:0]    flush_tag = '0;
  logic             commit_valid, commit_reg_write, commit_mem_write, exc_valid;
  logic [4:0]       commit_dest;
  logic [DW-1:0]    commit_value, exc_epc;
  logic [1:0]       exc_cause;
  logic [TW:0]      count;
`ifdef ROB_PERF_EN
  logic [31:0]      perf_commits, perf_full_cycles;
`endif

  rob_param #(.DEPTH(DEPTH), .WB_PORTS(WBP), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alloc_dest(alloc_dest), .alloc_reg_write(alloc_reg_write),
    .alloc_mem_write(alloc_mem_write), .alloc_pc(alloc_pc),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .wb_exc(wb_exc), .wb_cause(wb_cause),
    .flush_valid(flush_valid), .flush_tag(flush_tag),
    .commit_valid(commit_valid), .commit_dest(commit_dest), .commit_value(commit_value),
    .commit_reg_write(commit_reg_write), .commit_mem_write(commit_mem_write),
    .exc_valid(exc_valid), .exc_epc(exc_epc), .exc_cause(exc_cause),
    .count(count)
`ifdef ROB_PERF_EN
    , .perf_commits(perf_commits), .perf_full_cycles(perf_full_cycles)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input int p, input logic [3:0] tag, input logic [31:0] val,
                    input logic e, input logic [1:0] c);
    wb_valid[p]        = 1'b1;
    wb_tag[p*4 +: 4]   = tag;
    wb_value[p*32 +: 32] = val;
    wb_exc[p]          = e;
    wb_cause[p*2 +: 2] = c;
  endtask

  task automatic wb_clr();
    wb_valid = '0;
    wb_exc   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0; alloc_valid = 1'b0; flush_valid = 1'b0; wb_clr();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic alloc_n(input int n, input logic [31:0] pc0);
    alloc_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      alloc_pc = pc0 + 32'(i);
      alloc_dest = 5'(i + 1);
      step();
    end
    alloc_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_count", count, 0);
    chk("rst_ready", alloc_ready, 0);
    chk("rst_commit", commit_valid, 0);
    chk("rst_exc", exc_valid, 0);
    chk("rst_tag", alloc_tag, 0);
    rst = 1'b1;
    step();
    chk("post_rst_ready", alloc_ready, 1);

    // Fill to DEPTH, 17th request refused
    alloc_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("fill_tag", alloc_tag, i);
      alloc_pc = 32'(i);
      step();
    end
    chk("full_count", count, 16);
    chk("full_ready", alloc_ready, 0);
    step();
    chk("full_hold_count", count, 16);
    chk("full_hold_tag", alloc_tag, 0);
`ifdef ROB_PERF_EN
    chk("perf_full", perf_full_cycles, 1);
`endif
    alloc_valid = 1'b0;

    // Reset mid-flight discards a pending commit
    wb(0, 4'd0, 32'h1, 1'b0, 2'b00);
    step();
    wb_clr();
    rst = 1'b0;
    step();
    chk("midrst_commit", commit_valid, 0);
    chk("midrst_count", count, 0);
    chk("midrst_ready", alloc_ready, 0);
    rst = 1'b1;
    step();
    chk("midrst_commit2", commit_valid, 0);
    chk("midrst_exc2", exc_valid, 0);
    chk("midrst_count2", count, 0);

    // Out-of-order completion, in-order commit
    alloc_reg_write = 1'b1;
    alloc_n(4, 32'h10);
    alloc_reg_write = 1'b0;
    wb(0, 4'd3, 32'h33, 1'b0, 2'b00); step();
    wb(0, 4'd2, 32'h32, 1'b0, 2'b00); step();
    wb(0, 4'd1, 32'h31, 1'b0, 2'b00); step();
    chk("ooo_no_commit", commit_valid, 0);
    wb(0, 4'd0, 32'h30, 1'b0, 2'b00); step();
    wb_clr();
    chk("ooo_latency", commit_valid, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ooo_valid", commit_valid, 1);
      chk("ooo_value", commit_value, 32'h30 + i);
      chk("ooo_dest", commit_dest, i + 1);
    end
    chk("ooo_rw", commit_reg_write, 1);
    step();
    chk("ooo_done_valid", commit_valid, 0);
    chk("ooo_done_count", count, 0);

    // Port priority and same-cycle alloc/wb
    chk("prio_tag", alloc_tag, 4);
    alloc_valid = 1'b1;
    step(); step();
    wb(3, 4'd6, 32'h66, 1'b0, 2'b00);
    step();
    alloc_valid = 1'b0; wb_clr();
    wb(0, 4'd5, 32'hAAAA, 1'b0, 2'b00);
    wb(1, 4'd4, 32'h44, 1'b0, 2'b00);
    wb(2, 4'd5, 32'h5555, 1'b0, 2'b00);
    step();
    wb_clr();
    step();
    chk("prio_c4", commit_value, 32'h44);
    step();
    chk("prio_valid", commit_valid, 1);
    chk("prio_value", commit_value, 32'hAAAA);
    step();
    chk("samecyc_ignored", commit_valid, 0);
    chk("samecyc_count", count, 1);
    wb(0, 4'd6, 32'h77, 1'b0, 2'b00);
    step();
    wb_clr();
    step();
    chk("late_valid", commit_valid, 1);
    chk("late_value", commit_value, 32'h77);
    chk("late_count", count, 0);

    // Flush
    do_reset();
    alloc_n(8, 32'h200);
    flush_valid = 1'b1; flush_tag = 4'd3; alloc_valid = 1'b1;
    #1;
    chk("flush_ready", alloc_ready, 0);
    step();
    flush_valid = 1'b0; alloc_valid = 1'b0;
    chk("flush_count", count, 4);
    chk("flush_tag", alloc_tag, 4);
    wb(0, 4'd6, 32'h66, 1'b0, 2'b00);
    step();
    wb_clr();
    chk("flush_wb6_count", count, 4);
    chk("flush_wb6_commit", commit_valid, 0);
    flush_valid = 1'b1; flush_tag = 4'd10;
    step();
    flush_valid = 1'b0;
    chk("badflush_count", count, 4);
    chk("badflush_tag", alloc_tag, 4);
    for (int p = 0; p < 4; p++) wb(p, 4'(p), 32'hA0 + 32'(p), 1'b0, 2'b00);
    step();
    wb_clr();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("flush_commit", commit_value, 32'hA0 + i);
    end
    step();
    chk("flush_end_valid", commit_valid, 0);
    chk("flush_end_count", count, 0);

    // Precise exception beats simultaneous flush
    do_reset();
    alloc_valid = 1'b1; alloc_pc = 32'h100; step();
    alloc_pc = 32'h104; step();
    alloc_valid = 1'b0;
    wb(0, 4'd0, 32'h0, 1'b1, 2'b10);
    step();
    wb_clr();
    chk("exc_latency", exc_valid, 0);
    flush_valid = 1'b1; flush_tag = 4'd1;
    step();
    flush_valid = 1'b0;
    chk("exc_valid", exc_valid, 1);
    chk("exc_epc", exc_epc, 32'h100);
    chk("exc_cause", exc_cause, 2'b10);
    chk("exc_count", count, 0);
    chk("exc_commit", commit_valid, 0);
    chk("exc_tag", alloc_tag, 0);
    step();
    chk("exc_pulse", exc_valid, 0);
    chk("exc_epc_hold", exc_epc, 32'h100);

    // Flush and commit together
    alloc_n(4, 32'h300);
    wb(0, 4'd0, 32'h55, 1'b0, 2'b00);
    step();
    wb_clr();
    flush_valid = 1'b1; flush_tag = 4'd2;
    step();
    flush_valid = 1'b0;
    chk("fc_commit", commit_valid, 1);
    chk("fc_value", commit_value, 32'h55);
    chk("fc_count", count, 2);
    chk("fc_tag", alloc_tag, 3);

    // Wrap-around: 40 alloc/commit pairs
    do_reset();
    for (int i = 0; i < 40; i++) begin
      chk("wrap_tag", alloc_tag, i % 16);
      alloc_valid = 1'b1; alloc_pc = 32'(i);
      step();
      alloc_valid = 1'b0;
      wb(0, 4'(i % 16), 32'h1000 + 32'(i), 1'b0, 2'b00);
      step();
      wb_clr();
      step();
      chk("wrap_valid", commit_valid, 1);
      chk("wrap_value", commit_value, 32'h1000 + i);
    end
    chk("wrap_count", count, 0);
`ifdef ROB_PERF_EN
    chk("perf_commits", perf_commits, 40);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
